// File: rtl/pipelined_subtractor.sv
// ---------------------------------------------------------------------------
// pipelined_subtractor
//
// Purpose:
//   S-stage pipelined subtractor computing res = op1 - op2 - bin over W bits.
//   Each stage resolves one SW = W/S bit segment and hands its borrow to the
//   next stage. Full valid/ready flow control lets it drain into a stalling
//   consumer; empty stages absorb new data even while downstream is stalled.
//
// Parameters:
//   W          operand/result width, must be a multiple of S
//   S          number of pipeline stages
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   in_valid   op1/op2/bin valid this cycle
//   in_ready   block can accept this cycle (combinational from out_ready)
//   op1        minuend
//   op2        subtrahend
//   bin        borrow-in, subtracted at bit 0
//   out_valid  res/bout/ovf valid
//   out_ready  consumer accepts this cycle
//   res        difference modulo 2^W
//   bout       borrow-out (unsigned op1 < op2 + bin)
//   ovf        signed overflow
// ---------------------------------------------------------------------------
module pipelined_subtractor #(
  parameter int W = 128,
  parameter int S = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op1,
  input  logic [W-1:0] op2,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic         bout,
  output logic         ovf
);

  localparam int SW = W / S;

  if ((W % S) != 0) begin : g_param_check
    $error("pipelined_subtractor: W must be divisible by S");
  end

  for (genvar k = 0; k < S; k++) begin : g_stage
    // Operand bits still to be processed from this stage onward.
    localparam int RW = (S - k) * SW;

    logic [RW-1:0]       src_op1;
    logic [RW-1:0]       src_op2;
    logic                src_valid;
    logic                src_borrow;
    logic [SW:0]         seg_sum;
    logic [(k+1)*SW-1:0] nxt_res;

    logic                valid_q;
    logic                borrow_q;
    logic [(k+1)*SW-1:0] res_q;
    logic                load;
    logic                move;

    if (k == 0) begin : g_first
      assign src_op1    = op1;
      assign src_op2    = op2;
      assign src_valid  = in_valid;
      assign src_borrow = bin;
      assign nxt_res    = seg_sum[SW-1:0];
    end else begin : g_next
      assign src_op1    = g_stage[k-1].g_mid.op1_q;
      assign src_op2    = g_stage[k-1].g_mid.op2_q;
      assign src_valid  = g_stage[k-1].valid_q;
      assign src_borrow = g_stage[k-1].borrow_q;
      assign nxt_res    = {seg_sum[SW-1:0], g_stage[k-1].res_q};
    end

    // a - b - bi == a + ~b + ~bi (mod 2^SW); the carry out is the inverted borrow.
    assign seg_sum = {1'b0, src_op1[SW-1:0]} + {1'b0, ~src_op2[SW-1:0]}
                   + {{SW{1'b0}}, ~src_borrow};

    // A stage loads when it is empty or its contents move on this edge.
    assign load = ~valid_q | move;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        valid_q  <= 1'b0;
        borrow_q <= 1'b0;
        res_q    <= '0;
      end else if (load) begin
        valid_q  <= src_valid;
        borrow_q <= ~seg_sum[SW];
        res_q    <= nxt_res;
      end
    end

    if (k == S - 1) begin : g_last
      logic ovf_q;

      assign move = out_ready;

      // src_op1/src_op2 hold only the top segment here, so their MSB is the operand sign.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          ovf_q <= 1'b0;
        end else if (load) begin
          ovf_q <= (src_op1[RW-1] != src_op2[RW-1]) && (nxt_res[W-1] != src_op1[RW-1]);
        end
      end
    end else begin : g_mid
      logic [RW-SW-1:0] op1_q;
      logic [RW-SW-1:0] op2_q;

      assign move = g_stage[k+1].load;

      // Only the not-yet-consumed upper segments travel down the pipe.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          op1_q <= '0;
          op2_q <= '0;
        end else if (load) begin
          op1_q <= src_op1[RW-1:SW];
          op2_q <= src_op2[RW-1:SW];
        end
      end
    end
  end

  assign in_ready  = g_stage[0].load;
  assign out_valid = g_stage[S-1].valid_q;
  assign res       = g_stage[S-1].res_q;
  assign bout      = g_stage[S-1].borrow_q;
  assign ovf       = g_stage[S-1].g_last.ovf_q;

endmodule
